// File: rtl/ins_mem_arbiter.sv
// ins_mem_arbiter: round-robin arbiter sharing one single-port instruction memory
// (1-cycle registered read) among N_CORES fetch units.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   req              per-core fetch request, held with pc_addr until granted
//   pc_addr          packed PCs, core i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   gnt              one-hot combinational grant (address taken this cycle)
//   ins_valid        one-hot registered owner strobe for ins_data
//   ins_data         broadcast read data (mem_instruction passthrough)
//   mem_addr/mem_rEn memory address / read enable
//   mem_instruction  memory read data
//
// Optional feature: define INS_ARB_BURST_EN to let a core keep priority for up to
// MAX_BURST consecutive grants while it keeps requesting.

module ins_mem_arbiter #(
  parameter int unsigned N_CORES    = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned INS_WIDTH  = 9,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CORES-1:0]            req,
  input  logic [N_CORES*ADDR_WIDTH-1:0] pc_addr,
  output logic [N_CORES-1:0]            gnt,
  output logic [N_CORES-1:0]            ins_valid,
  output logic [INS_WIDTH-1:0]          ins_data,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_rEn,
  input  logic [INS_WIDTH-1:0]          mem_instruction
);

  localparam int unsigned PTR_W = $clog2(N_CORES);

  if (N_CORES < 2 || MAX_BURST < 1) begin : g_bad_params
    $error("ins_mem_arbiter: N_CORES must be >= 2 and MAX_BURST >= 1");
  end

  logic [PTR_W-1:0]   prio_q, prio_d;
  logic [PTR_W-1:0]   win_idx, win_next, scan_idx;
  logic               win_found;
  logic [N_CORES-1:0] owner_q, owner_d;
  int unsigned        scan_sum;

  // Scan req starting at prio_q, wrapping modulo N_CORES; first hit wins.
  // Reset masks every grant so no read is issued while rst is high.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = 0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < N_CORES; k++) begin
      scan_sum = 32'(prio_q) + k;
      if (scan_sum >= N_CORES) scan_sum = scan_sum - N_CORES;
      scan_idx = PTR_W'(scan_sum);
      if (!rst && !win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign win_next = (win_idx == PTR_W'(N_CORES - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    gnt = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      gnt[i] = win_found && (win_idx == PTR_W'(i));
    end
  end

  assign mem_rEn  = win_found;
  assign mem_addr = win_found ? pc_addr[32'(win_idx) * ADDR_WIDTH +: ADDR_WIDTH] : '0;

  // Owner follows the grant with one cycle of latency, matching the memory read.
  assign owner_d   = gnt;
  assign ins_valid = owner_q;
  assign ins_data  = mem_instruction;

`ifdef INS_ARB_BURST_EN
  localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d, cnt_base;
  logic [PTR_W-1:0] prio_inc;

  assign prio_inc = (prio_q == PTR_W'(N_CORES - 1)) ? '0 : prio_q + 1'b1;

  // burst_cnt always belongs to the core at prio_q; a grant elsewhere starts a new burst.
  always_comb begin
    prio_d      = prio_q;
    burst_cnt_d = burst_cnt_q;
    cnt_base    = (win_idx == prio_q) ? burst_cnt_q : '0;
    if (win_found) begin
      if (32'(cnt_base) < MAX_BURST - 1) begin
        prio_d      = win_idx;
        burst_cnt_d = cnt_base + 1'b1;
      end else begin
        prio_d      = win_next;
        burst_cnt_d = '0;
      end
    end else if (burst_cnt_q != '0 && !req[prio_q]) begin
      // Burst owner dropped its request with nobody else waiting: end the burst.
      prio_d      = prio_inc;
      burst_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  always_comb begin
    prio_d = win_found ? win_next : prio_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q  <= '0;
      owner_q <= '0;
    end else begin
      prio_q  <= prio_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_ins_mem_arbiter.sv
module tb_ins_mem_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned IW = 9;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] pc_addr;
  logic [N-1:0]    gnt;
  logic [N-1:0]    ins_valid;
  logic [IW-1:0]   ins_data;
  logic [AW-1:0]   mem_addr;
  logic            mem_rEn;
  logic [IW-1:0]   mem_q;

  int checks   = 0;
  int failures = 0;

  ins_mem_arbiter #(
    .N_CORES   (N),
    .ADDR_WIDTH(AW),
    .INS_WIDTH (IW),
    .MAX_BURST (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .pc_addr        (pc_addr),
    .gnt            (gnt),
    .ins_valid      (ins_valid),
    .ins_data       (ins_data),
    .mem_addr       (mem_addr),
    .mem_rEn        (mem_rEn),
    .mem_instruction(mem_q)
  );

  always #5 clk = ~clk;

  // Instruction memory model: registered read, mem[a] = {1'b1, a}.
  initial mem_q = '0;
  always @(posedge clk) begin
    if (mem_rEn) mem_q <= {1'b1, mem_addr};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pcs(input logic [7:0] p0, input logic [7:0] p1,
                         input logic [7:0] p2, input logic [7:0] p3);
    pc_addr = {p3, p2, p1, p0};
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    set_pcs(8'h01, 8'h02, 8'h03, 8'h04);
    #1;
    checks++;
    if (gnt !== 4'b0000) begin
      failures++; $display("FAIL reset_gnt: got %b expected 0000", gnt);
    end
    checks++;
    if (mem_rEn !== 1'b0) begin
      failures++; $display("FAIL reset_rEn: got %b expected 0", mem_rEn);
    end
    checks++;
    if (mem_addr !== 8'h00) begin
      failures++; $display("FAIL reset_addr: got %h expected 00", mem_addr);
    end
    tick();
    #1;
    checks++;
    if (ins_valid !== 4'b0000) begin
      failures++; $display("FAIL reset_valid: got %b expected 0000", ins_valid);
    end
    rst = 1'b0;
    req = '0;
    tick();
  endtask

  task automatic test_single();
    req = 4'b0100;
    set_pcs(8'h00, 8'h00, 8'h05, 8'h00);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (gnt !== 4'b0100) begin
        failures++; $display("FAIL single_gnt[%0d]: got %b expected 0100", c, gnt);
      end
      checks++;
      if (mem_addr !== 8'h05) begin
        failures++; $display("FAIL single_addr[%0d]: got %h expected 05", c, mem_addr);
      end
      checks++;
      if (ins_valid !== ((c == 0) ? 4'b0000 : 4'b0100)) begin
        failures++; $display("FAIL single_valid[%0d]: got %b", c, ins_valid);
      end
      if (c > 0) begin
        checks++;
        if (ins_data !== 9'h105) begin
          failures++; $display("FAIL single_data[%0d]: got %h expected 105", c, ins_data);
        end
      end
      tick();
    end
    req = '0;
    #1;
    checks++;
    if (ins_valid !== 4'b0100 || ins_data !== 9'h105) begin
      failures++; $display("FAIL single_tail: got %b/%h expected 0100/105", ins_valid, ins_data);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int          exp_core [5] = '{0, 1, 2, 3, 0};
    logic [3:0]  exp_g;
    logic [7:0]  exp_a;
    logic [8:0]  exp_d;
    apply_reset();
    req = 4'b1111;
    set_pcs(8'h0A, 8'h0B, 8'h0C, 8'h0D);
    for (int i = 0; i < 5; i++) begin
      #1;
      exp_g = 4'b0001 << exp_core[i];
      exp_a = 8'h0A + 8'(exp_core[i]);
      checks++;
      if (gnt !== exp_g) begin
        failures++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt, exp_g);
      end
      checks++;
      if (mem_addr !== exp_a) begin
        failures++; $display("FAIL rr_addr[%0d]: got %h expected %h", i, mem_addr, exp_a);
      end
      if (i > 0) begin
        exp_g = 4'b0001 << exp_core[i-1];
        exp_d = {1'b1, 8'h0A + 8'(exp_core[i-1])};
        checks++;
        if (ins_valid !== exp_g) begin
          failures++; $display("FAIL rr_valid[%0d]: got %b expected %b", i, ins_valid, exp_g);
        end
        checks++;
        if (ins_data !== exp_d) begin
          failures++; $display("FAIL rr_data[%0d]: got %h expected %h", i, ins_data, exp_d);
        end
      end
      tick();
    end
  endtask

  // Follows test_round_robin: pointer is at core 1, core 0 data still returning.
  task automatic test_idle();
    req = '0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || mem_rEn !== 1'b0) begin
      failures++; $display("FAIL idle_gnt: got %b/%b expected 0000/0", gnt, mem_rEn);
    end
    checks++;
    if (ins_valid !== 4'b0001 || ins_data !== 9'h10A) begin
      failures++; $display("FAIL idle_last: got %b/%h expected 0001/10A", ins_valid, ins_data);
    end
    tick();
    #1;
    checks++;
    if (ins_valid !== 4'b0000) begin
      failures++; $display("FAIL idle_valid: got %b expected 0000", ins_valid);
    end
    tick();
    req = 4'b1111;
    #1;
    checks++;
    if (gnt !== 4'b0010) begin
      failures++; $display("FAIL idle_ptr_kept: got %b expected 0010", gnt);
    end
    tick();
    req = '0;
    #1;
    checks++;
    if (ins_valid !== 4'b0010 || ins_data !== 9'h10B) begin
      failures++; $display("FAIL idle_resume: got %b/%h expected 0010/10B", ins_valid, ins_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    set_pcs(8'h0A, 8'h0B, 8'h0C, 8'h0D);
    req = 4'b0010;
    #1;
    checks++;
    if (gnt !== 4'b0010) begin
      failures++; $display("FAIL rmid_pre_gnt: got %b expected 0010", gnt);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000 || mem_rEn !== 1'b0) begin
      failures++; $display("FAIL rmid_gnt: got %b/%b expected 0000/0", gnt, mem_rEn);
    end
    tick();
    rst = 1'b0;
    req = 4'b1111;
    #1;
    checks++;
    if (ins_valid !== 4'b0000) begin
      failures++; $display("FAIL rmid_valid: got %b expected 0000", ins_valid);
    end
    checks++;
    if (gnt !== 4'b0001) begin
      failures++; $display("FAIL rmid_first_gnt: got %b expected 0001", gnt);
    end
    tick();
    req = '0;
    #1;
    checks++;
    if (ins_valid !== 4'b0001 || ins_data !== 9'h10A) begin
      failures++; $display("FAIL rmid_data: got %b/%h expected 0001/10A", ins_valid, ins_data);
    end
    tick();
  endtask

`ifdef INS_ARB_BURST_EN
  task automatic test_burst();
    int         exp_core [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    logic [3:0] exp_g;
    apply_reset();
    req = 4'b0011;
    set_pcs(8'h20, 8'h21, 8'h00, 8'h00);
    for (int i = 0; i < 9; i++) begin
      #1;
      exp_g = 4'b0001 << exp_core[i];
      checks++;
      if (gnt !== exp_g) begin
        failures++; $display("FAIL burst_gnt[%0d]: got %b expected %b", i, gnt, exp_g);
      end
      tick();
    end
    apply_reset();
    req = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (gnt !== 4'b0001) begin
        failures++; $display("FAIL burst_drop_pre[%0d]: got %b expected 0001", i, gnt);
      end
      tick();
    end
    req = 4'b0010;
    #1;
    checks++;
    if (gnt !== 4'b0010) begin
      failures++; $display("FAIL burst_drop: got %b expected 0010", gnt);
    end
    tick();
    req = '0;
    tick();
  endtask
`else
  task automatic test_wrap();
    int         exp_core [4] = '{0, 3, 0, 3};
    logic [3:0] exp_g;
    logic [8:0] exp_d;
    apply_reset();
    req = 4'b1001;
    set_pcs(8'h30, 8'h00, 8'h00, 8'h33);
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_g = 4'b0001 << exp_core[i];
      checks++;
      if (gnt !== exp_g) begin
        failures++; $display("FAIL wrap_gnt[%0d]: got %b expected %b", i, gnt, exp_g);
      end
      if (i > 0) begin
        exp_g = 4'b0001 << exp_core[i-1];
        exp_d = (exp_core[i-1] == 0) ? 9'h130 : 9'h133;
        checks++;
        if (ins_valid !== exp_g || ins_data !== exp_d) begin
          failures++;
          $display("FAIL wrap_ret[%0d]: got %b/%h expected %b/%h", i, ins_valid, ins_data,
                   exp_g, exp_d);
        end
      end
      tick();
    end
    req = '0;
    tick();
  endtask
`endif

  initial begin
    rst     = 1'b1;
    req     = '0;
    pc_addr = '0;
    test_reset();
    test_single();
`ifdef INS_ARB_BURST_EN
    test_reset_mid();
    test_burst();
`else
    test_round_robin();
    test_idle();
    test_reset_mid();
    test_wrap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
